// File: rtl/gf_div_pkg.sv
// Shared GF(2^8) constants and divider FSM state type.
package gf_pkg;

  localparam logic [7:0] GF_POLY        = 8'h1D;
  localparam int         GF_DIV_LATENCY = 10;
  localparam logic [7:0] GF_INV_EXP     = 8'hFE;
  localparam int         GF_CNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXP  = 2'd1,
    MULT = 2'd2
  } gf_state_e;

endpackage

// File: rtl/gf_div_if.sv
// Request/result bundle between a GF(2^8) divider and its client.
interface gf_div_if;

  logic       start;
  logic [7:0] in_1;
  logic [7:0] in_2;
  logic [7:0] out;
  logic       done;
  logic       busy;
  logic       div_by_zero;

  modport master (
    output start, in_1, in_2,
    input  out, done, busy, div_by_zero
  );

  modport slave (
    input  start, in_1, in_2,
    output out, done, busy, div_by_zero
  );

endinterface

// File: rtl/gf_div_mul_comb.sv
// Combinational 8x8 GF(2^8) multiply, reduced by {1,POLY} at every shift step.
module gf_mul_comb #(
  parameter logic [7:0] POLY = gf_pkg::GF_POLY
) (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = 8'h00;
    sh  = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY : 8'h00);
    end
    p_o = acc;
  end

endmodule

// File: rtl/gf_div.sv
// Constant-time GF(2^8) divider: out = in_1 * in_2^254, done 10 edges after the start edge.
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   EXP   | square-and-multiply, 8 steps over exponent bits 7..0
//   MULT  | cnt==7: r <= a*r ; otherwise publish r with done
module gf_div
  import gf_pkg::*;
#(
  parameter logic [7:0] POLY    = GF_POLY,
  parameter int         LATENCY = GF_DIV_LATENCY
) (
  input logic   clk,
  input logic   rst_n,
  gf_div_if.slave bus
);

  if (LATENCY != GF_DIV_LATENCY) begin : g_latency_check
    $error("gf_div: LATENCY must be 10");
  end

  gf_state_e             state_q;
  logic [GF_CNT_W-1:0]   cnt_q;
  logic [7:0]            a_q;
  logic [7:0]            b_q;
  logic [7:0]            r_q;
  logic [7:0]            out_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  dbz_q;

  logic [7:0] sq;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] prod;

  gf_mul_comb #(.POLY(POLY)) u_sq (
    .a_i (r_q),
    .b_i (r_q),
    .p_o (sq)
  );

  // Second multiplier is shared: sq(r)*(b|1) during EXP, a*r during MULT.
  always_comb begin
    op_a = sq;
    op_b = GF_INV_EXP[cnt_q] ? b_q : 8'h01;
    if (state_q == MULT) begin
      op_a = a_q;
      op_b = r_q;
    end
  end

  gf_mul_comb #(.POLY(POLY)) u_mul (
    .a_i (op_a),
    .b_i (op_b),
    .p_o (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      r_q     <= 8'h00;
      out_q   <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // busy_q is still high during the done cycle, so start is not sampled there
          if (bus.start && !busy_q) begin
            a_q     <= bus.in_1;
            b_q     <= bus.in_2;
            r_q     <= 8'h01;
            cnt_q   <= GF_CNT_W'(7);
            busy_q  <= 1'b1;
            state_q <= EXP;
          end else begin
            busy_q <= 1'b0;
          end
        end
        EXP: begin
          r_q   <= prod;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= MULT;
        end
        MULT: begin
          // cnt wrapped to 7 on entry; it marks the product cycle vs. the publish cycle
          if (cnt_q == GF_CNT_W'(7)) begin
            r_q   <= prod;
            cnt_q <= cnt_q - 1'b1;
          end else begin
            out_q   <= r_q;
            done_q  <= 1'b1;
            dbz_q   <= (b_q == 8'h00);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out         = out_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf_div.sv
// Self-checking bench for gf_div: vector table, hand sequences, random ops vs. field model.
module tb_gf_div;

  logic clk;
  logic rst_n;

  gf_div_if bus_if ();

  gf_div u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] inv_tab [256];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic       dbz;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Field model: carry-less product then polynomial long division by x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (15'(9'h11D) << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'h00) return 8'h00;
    return ref_mul(a, inv_tab[b]);
  endfunction

  // Issues one op; scrambles operands after acceptance; optionally pokes start at +3/+7.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit inject,
                        output logic [7:0] q, output logic dbz, output int lat);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.in_1  = a;
    bus_if.in_2  = b;
    @(posedge clk);
    lat = -1;
    q   = 8'h00;
    dbz = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      bus_if.in_1  = 8'($urandom);
      bus_if.in_2  = 8'($urandom);
      bus_if.start = inject && (k == 2 || k == 6);
      if (bus_if.done) begin
        lat = k;
        q   = bus_if.out;
        dbz = bus_if.div_by_zero;
        break;
      end
    end
    bus_if.start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q, q_prev;
  logic       dbz;
  int         lat;
  int         dones;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 1; b < 256; b++)
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(b), 8'(y)) == 8'h01) inv_tab[b] = 8'(y);
    inv_tab[0] = 8'h00;

    vecs[0] = '{8'h01, 8'h02, 8'h8E, 1'b0};
    vecs[1] = '{8'h03, 8'h03, 8'h01, 1'b0};
    vecs[2] = '{8'h02, 8'h8E, 8'h04, 1'b0};
    vecs[3] = '{8'h57, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{8'h00, 8'h57, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'h01, 8'hFF, 1'b0};
    vecs[6] = '{8'h01, 8'h01, 8'h01, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b1};

    bus_if.start = 1'b0;
    bus_if.in_1  = 8'h00;
    bus_if.in_2  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out",  int'(bus_if.out), 0);
    chk("reset_done", int'(bus_if.done), 0);
    chk("reset_busy", int'(bus_if.busy), 0);
    chk("reset_dbz",  int'(bus_if.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, q, dbz, lat);
      chk($sformatf("vec%0d_out", i), int'(q), int'(vecs[i].q));
      chk($sformatf("vec%0d_dbz", i), int'(dbz), int'(vecs[i].dbz));
      chk($sformatf("vec%0d_lat", i), lat, 10);
      chk($sformatf("vec%0d_done_drop", i), int'(bus_if.done), 0);
      chk($sformatf("vec%0d_dbz_drop", i), int'(bus_if.div_by_zero), 0);
      chk($sformatf("vec%0d_busy_drop", i), int'(bus_if.busy), 0);
      chk($sformatf("vec%0d_out_hold", i), int'(bus_if.out), int'(vecs[i].q));
    end

    // Start pulses while busy must be ignored: one done, first operands' result.
    run_op(8'h01, 8'h02, 1'b1, q, dbz, lat);
    chk("ignore_out", int'(q), 8'h8E);
    chk("ignore_lat", lat, 10);
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) dones++;
    end
    chk("ignore_extra_done", dones, 0);
    chk("ignore_out_hold", int'(bus_if.out), 8'h8E);

    // Reset mid-operation: outputs clear immediately, no done appears.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.in_1  = 8'h12;
    bus_if.in_2  = 8'h34;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_busy_before", int'(bus_if.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out",  int'(bus_if.out), 0);
    chk("midrst_busy", int'(bus_if.busy), 0);
    chk("midrst_done", int'(bus_if.done), 0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) dones++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run_op(8'h12, 8'h34, 1'b0, q, dbz, lat);
    chk("postrst_out", int'(q), int'(ref_div(8'h12, 8'h34)));
    chk("postrst_lat", lat, 10);

    // Random back-to-back ops against the field model.
    q_prev = q;
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = (n % 50 == 0) ? 8'h00 : 8'($urandom);
      run_op(a, b, 1'b0, q, dbz, lat);
      chk($sformatf("rnd%0d_out(%02h/%02h)", n, a, b), int'(q), int'(ref_div(a, b)));
      chk($sformatf("rnd%0d_dbz", n), int'(dbz), int'(b == 8'h00));
      chk($sformatf("rnd%0d_lat", n), lat, 10);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
